// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets several requesters share one UART
// transmitter. Only one frame is in flight at a time. The owning requester is
// released on the transmitter's done pulse, or after a bounded wait if the
// pulse never arrives.
module uart_tx_arb #(
    parameter int num_req_p        = 4,
    parameter int data_bits_p      = 8,
    parameter int timeout_cycles_p = 200000,
    localparam int grant_w_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*data_bits_p-1:0] req_data_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic                             tx_v_o,
    output logic [data_bits_p-1:0]           tx_data_o,
    input  logic                             tx_done_i,
    output logic                             busy_o,
    output logic [grant_w_lp-1:0]            grant_id_o,
    output logic                             timeout_o
);

    localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0]   cnt_limit_lp = cnt_w_lp'(timeout_cycles_p - 1);
    localparam logic [grant_w_lp-1:0] last_idx_lp  = grant_w_lp'(num_req_p - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                  state_r;
    state_e                  state_n;
    logic [grant_w_lp-1:0]   ptr_r;
    logic [cnt_w_lp-1:0]     cnt_r;
    logic [data_bits_p-1:0]  req_arr [num_req_p];
    logic                    win_found;
    logic [grant_w_lp-1:0]   win_idx;
    logic [grant_w_lp-1:0]   cand;
    logic [grant_w_lp-1:0]   next_ptr;
    logic                    accept;
    logic                    done_evt;
    logic                    timeout_evt;

    // Unpack the flat character bus so the winner can be selected by index.
    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign req_arr[g] = req_data_i[g*data_bits_p +: data_bits_p];
    end

    // After a frame ends, priority starts at the requester just past the owner.
    assign next_ptr = (grant_id_o == last_idx_lp) ? '0 : grant_id_o + grant_w_lp'(1);

    // Scan requesters upward from the priority pointer, wrapping, and take the first valid one.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_r;
        for (int k = 0; k < num_req_p; k++) begin
            if (!win_found && req_v_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == last_idx_lp) ? '0 : cand + grant_w_lp'(1);
        end
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and decoded outputs; done outranks timeout in the same cycle.
    always_comb begin
        state_n     = state_r;
        req_ready_o = '0;
        tx_v_o      = 1'b0;
        busy_o      = 1'b1;
        accept      = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state_r)
            IDLE: begin
                busy_o = 1'b0;
                if (win_found) begin
                    req_ready_o[win_idx] = 1'b1;
                    accept               = 1'b1;
                    state_n              = ISSUE;
                end
            end
            ISSUE: begin
                tx_v_o  = 1'b1;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_i) begin
                    done_evt = 1'b1;
                    state_n  = IDLE;
                end else if (cnt_r == cnt_limit_lp) begin
                    timeout_evt = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Frame registers: capture on accept, count the wait, move priority when a frame ends.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r      <= '0;
            cnt_r      <= '0;
            tx_data_o  <= '0;
            grant_id_o <= '0;
            timeout_o  <= 1'b0;
        end else begin
            timeout_o <= timeout_evt;
            if (accept) begin
                tx_data_o  <= req_arr[win_idx];
                grant_id_o <= win_idx;
            end
            if (state_r == ISSUE) begin
                cnt_r <= '0;
            end else if (state_r == WAIT_DONE) begin
                cnt_r <= cnt_r + cnt_w_lp'(1);
            end
            if (done_evt || timeout_evt) begin
                ptr_r <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: drives frames through the arbiter and compares its behaviour
// against a transaction-level model that tracks only the priority pointer.
module tb_uart_tx_arb;

    localparam int NUM     = 4;
    localparam int DBITS   = 8;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             reset_n;
    logic [NUM-1:0]   req_v;
    logic [NUM*DBITS-1:0] req_data;
    logic [NUM-1:0]   req_ready;
    logic             tx_v;
    logic [DBITS-1:0] tx_data;
    logic             tx_done;
    logic             busy;
    logic [1:0]       grant_id;
    logic             timeout;

    int checkCount = 0;
    int passCount  = 0;
    int modelPtr   = 0;

    uart_tx_arb #(
        .num_req_p(NUM),
        .data_bits_p(DBITS),
        .timeout_cycles_p(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .req_v_i(req_v),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .tx_v_o(tx_v),
        .tx_data_o(tx_data),
        .tx_done_i(tx_done),
        .busy_o(busy),
        .grant_id_o(grant_id),
        .timeout_o(timeout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // First requester with a valid bit, scanning upward from p with wrap.
    function automatic int pickWinner(input logic [NUM-1:0] m, input int p);
        for (int k = 0; k < NUM; k++) begin
            if (m[(p + k) % NUM]) return (p + k) % NUM;
        end
        return 0;
    endfunction

    task automatic checkResetOutputs(input string where);
        checkOutput({where, "_tx_v"},    32'(tx_v),     32'd0);
        checkOutput({where, "_tx_data"}, 32'(tx_data),  32'd0);
        checkOutput({where, "_grant"},   32'(grant_id), 32'd0);
        checkOutput({where, "_timeout"}, 32'(timeout),  32'd0);
        checkOutput({where, "_busy"},    32'(busy),     32'd0);
    endtask

    // One IDLE cycle with no requests: nothing accepted, still idle.
    task automatic applyIdle();
        @(negedge clk);
        req_v = '0;
        #1;
        checkOutput("noreq_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("noreq_busy", 32'(busy), 32'd0);
    endtask

    // One frame: offer mask/data, expect the model's winner, then return done in
    // WAIT_DONE cycle doneAt (>= TIMEOUT means never), optionally glitch done in
    // ISSUE, or pull reset in WAIT_DONE cycle abortAt.
    task automatic applyStimulus(input logic [NUM-1:0] mask, input logic [NUM*DBITS-1:0] data,
                                 input int doneAt, input bit glitch, input int abortAt);
        int win;
        logic [DBITS-1:0] expData;
        win     = pickWinner(mask, modelPtr);
        expData = data[win*DBITS +: DBITS];

        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_timeout", 32'(timeout), 32'd0);
        req_v    = mask;
        req_data = data;
        #1;
        checkOutput("ready_onehot", 32'(req_ready), 32'(1 << win));

        @(posedge clk); #1;
        checkOutput("issue_tx_v",  32'(tx_v),     32'd1);
        checkOutput("issue_data",  32'(tx_data),  32'(expData));
        checkOutput("issue_grant", 32'(grant_id), 32'(win));
        checkOutput("issue_busy",  32'(busy),     32'd1);
        req_v   = 4'($urandom_range(0, 15));
        tx_done = glitch;
        #1;
        checkOutput("issue_ready", 32'(req_ready), 32'd0);

        @(posedge clk); #1;
        tx_done = 1'b0;
        checkOutput("wait_tx_v",  32'(tx_v),  32'd0);
        checkOutput("wait_busy",  32'(busy),  32'd1);
        checkOutput("wait_ready", 32'(req_ready), 32'd0);

        for (int k = 0; k < TIMEOUT; k++) begin
            if (k == abortAt) begin
                #2;
                reset_n = 1'b0;
                #1;
                checkResetOutputs("async_reset");
                @(negedge clk);
                reset_n  = 1'b1;
                req_v    = '0;
                modelPtr = 0;
                return;
            end
            tx_done = (k == doneAt);
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (k == doneAt) begin
                checkOutput("done_busy", 32'(busy), 32'd0);
                checkOutput("done_timeout", 32'(timeout), 32'd0);
                checkOutput("done_grant_hold", 32'(grant_id), 32'(win));
                break;
            end
            if (k == TIMEOUT - 1) begin
                checkOutput("timeout_pulse", 32'(timeout), 32'd1);
                checkOutput("timeout_busy", 32'(busy), 32'd0);
                req_v = '0;
                @(posedge clk); #1;
                checkOutput("timeout_one_cycle", 32'(timeout), 32'd0);
            end else if (busy !== 1'b1) begin
                checkOutput("wait_early_exit", 32'(busy), 32'd1);
                break;
            end
        end
        req_v    = '0;
        modelPtr = (win + 1) % NUM;
    endtask

    // Test sequence: reset, directed cases, random frames, async reset mid-frame.
    initial begin
        reset_n  = 1'b0;
        req_v    = '0;
        req_data = '0;
        tx_done  = 1'b0;
        #2;
        checkResetOutputs("reset");
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        modelPtr = 0;

        // All requesting: grants rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hF, 32'($urandom), 2, 1'b0, -1);
        end

        // Single requester 2 with 'A'.
        applyStimulus(4'b0100, 32'h0041_0000, 3, 1'b0, -1);

        // Pointer at 3 with requesters 3 and 0: grant 3, then 0.
        applyStimulus(4'b1001, 32'($urandom), 1, 1'b0, -1);
        applyStimulus(4'b1001, 32'($urandom), 1, 1'b0, -1);

        // No done at all, done coincident with timeout, done glitch during ISSUE.
        applyStimulus(4'($urandom_range(1, 15)), 32'($urandom), TIMEOUT + 4, 1'b0, -1);
        applyStimulus(4'($urandom_range(1, 15)), 32'($urandom), TIMEOUT - 1, 1'b0, -1);
        applyStimulus(4'($urandom_range(1, 15)), 32'($urandom), 0, 1'b1, -1);

        applyIdle();
        applyIdle();

        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), 32'($urandom),
                          int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 3) == 0) applyIdle();
        end

        // Move priority away from 0, abort a frame by reset, then priority restarts at 0.
        applyStimulus(4'b0100, 32'($urandom), 0, 1'b0, -1);
        applyStimulus(4'b0010, 32'($urandom), TIMEOUT + 4, 1'b0, 5);
        applyStimulus(4'hF, 32'($urandom), 1, 1'b0, -1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
